// File: rtl/lsu_data_port_pkg.sv
// Shared types and constants for the LSU data port: FSM states, access sizes, fault causes.
package lsu_data_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  localparam logic [1:0] FC_MISALIGN = 2'd0;
  localparam logic [1:0] FC_ILLEGAL  = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

  function automatic logic size_legal(input logic [2:0] sz);
    return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W);
  endfunction

endpackage

// File: rtl/lsu_data_port_lane_align.sv
// Byte-lane steering: store strobes and shifted write data, load byte/half extract and extend.
module lsu_lane_align
  import lsu_data_port_pkg::*;
(
  input  logic [1:0]  i_st_lo,
  input  logic [2:0]  i_st_size,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_lo,
  input  logic [2:0]  i_ld_size,
  input  logic        i_ld_sign,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_rshift;

  always_comb begin
    case (i_st_size)
      SZ_B:    o_wstrb = 4'b0001 << i_st_lo;
      SZ_H:    o_wstrb = 4'b0011 << i_st_lo;
      SZ_W:    o_wstrb = 4'b1111;
      default: o_wstrb = 4'b0000;
    endcase
    o_wdata  = i_st_wdata << {i_st_lo, 3'b000};

    // Bring the addressed lane down to bit 0, then extend from its top bit.
    w_rshift = i_rdata >> {i_ld_lo, 3'b000};
    case (i_ld_size)
      SZ_B:    o_ld_data = {{24{i_ld_sign & w_rshift[7]}}, w_rshift[7:0]};
      SZ_H:    o_ld_data = {{16{i_ld_sign & w_rshift[15]}}, w_rshift[15:0]};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_data_port.sv
// LSU data port: accepts one EX-stage load/store, checks alignment, runs a word bus access,
// and returns the extended load result while stalling the pipeline.
//
//   state | meaning
//   IDLE  | waiting; a request here is checked and accepted (stall high this cycle)
//   REQ   | mem_req asserted, waiting for mem_gnt (watchdog running)
//   RESP  | load granted, waiting for mem_rvalid (watchdog running)
//   DONE  | access complete; stall low, load_valid pulses for loads
module lsu_data_port
  import lsu_data_port_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_mem,
  input  logic              i_store_mem,
  input  logic [2:0]        i_size,
  input  logic              i_sign,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic [31:0]       o_load_data,
  output logic              o_load_valid,
  output logic              o_fault,
  output logic [1:0]        o_fault_cause,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_wstrb,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  localparam int unsigned WD_W  = 16;
  localparam logic        WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic              r_is_load;
  logic [2:0]        r_size;
  logic              r_sign;
  logic [1:0]        r_addr_lo;
  logic [WD_W-1:0]   r_wd_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_wstrb;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_load_data;
  logic              r_load_valid;
  logic              r_fault;
  logic [1:0]        r_fault_cause;

  logic        w_req;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_wd_expired;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_ld_ext;

  assign w_req        = i_load_mem | i_store_mem;
  assign w_illegal    = (i_load_mem & i_store_mem) | ~size_legal(i_size);
  assign w_misalign   = ((i_size == SZ_H) & i_addr[0]) | ((i_size == SZ_W) & (i_addr[1:0] != 2'b00));
  assign w_wd_expired = WD_EN & (r_wd_cnt == WD_LAST);

  lsu_lane_align u_align (
    .i_st_lo    (i_addr[1:0]),
    .i_st_size  (i_size),
    .i_st_wdata (i_wdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata_sh),
    .i_ld_lo    (r_addr_lo),
    .i_ld_size  (r_size),
    .i_ld_sign  (r_sign),
    .i_rdata    (i_mem_rdata),
    .o_ld_data  (w_ld_ext)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_is_load     <= 1'b0;
      r_size        <= '0;
      r_sign        <= 1'b0;
      r_addr_lo     <= '0;
      r_wd_cnt      <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wstrb   <= '0;
      r_mem_wdata   <= '0;
      r_load_data   <= '0;
      r_load_valid  <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_cause <= '0;
    end else begin
      r_fault      <= 1'b0;
      r_load_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_is_load <= i_load_mem;
            r_size    <= i_size;
            r_sign    <= i_sign;
            r_addr_lo <= i_addr[1:0];
            if (w_illegal) begin
              r_fault       <= 1'b1;
              r_fault_cause <= FC_ILLEGAL;
            end else if (w_misalign) begin
              r_fault       <= 1'b1;
              r_fault_cause <= FC_MISALIGN;
            end else begin
              r_state     <= REQ;
              r_wd_cnt    <= '0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_store_mem;
              r_mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
              r_mem_wstrb <= w_wstrb;
              r_mem_wdata <= w_wdata_sh;
            end
          end
        end
        REQ: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            r_wd_cnt  <= '0;
            r_state   <= r_is_load ? RESP : DONE;
          end else if (w_wd_expired) begin
            r_mem_req     <= 1'b0;
            r_fault       <= 1'b1;
            r_fault_cause <= FC_TIMEOUT;
            r_state       <= IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (i_mem_rvalid) begin
            r_load_data  <= w_ld_ext;
            r_load_valid <= 1'b1;
            r_state      <= DONE;
          end else if (w_wd_expired) begin
            r_fault       <= 1'b1;
            r_fault_cause <= FC_TIMEOUT;
            r_state       <= IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_stall       = (r_state == REQ) | (r_state == RESP) | ((r_state == IDLE) & w_req);
  assign o_load_data   = r_load_data;
  assign o_load_valid  = r_load_valid;
  assign o_fault       = r_fault;
  assign o_fault_cause = r_fault_cause;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wstrb   = r_mem_wstrb;
  assign o_mem_wdata   = r_mem_wdata;

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed and randomized load/store traffic against a byte-level reference model of the LSU port.
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_mem, store_mem, sign;
  logic [2:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, fault, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [1:0]  fault_cause;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_ld = 32'h0;

  always #5 clk = ~clk;

  lsu_data_port #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_load_mem(load_mem), .i_store_mem(store_mem),
    .i_size(size), .i_sign(sign), .i_addr(addr), .i_wdata(wdata),
    .o_stall(stall), .o_load_data(load_data), .o_load_valid(load_valid),
    .o_fault(fault), .o_fault_cause(fault_cause), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wstrb(mem_wstrb),
    .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // -1 when legal, otherwise the fault cause
  function automatic int m_fault(input bit ld, input bit st, input int sz, input logic [31:0] a);
    if ((ld && st) || !(sz == 1 || sz == 2 || sz == 4)) return 1;
    if ((a % sz) != 0) return 0;
    return -1;
  endfunction

  function automatic logic [3:0] m_strb(input int sz, input int lo);
    logic [3:0] s = 4'b0;
    for (int b = 0; b < 4; b++)
      if (b >= lo && b < lo + sz) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_load(input int sz, input bit sg, input int lo, input logic [31:0] rd);
    longint unsigned v, mask;
    if (sz == 4) return rd;
    mask = (64'd1 << (8 * sz)) - 1;
    v = (longint'(rd) >> (8 * lo)) & mask;
    if (sg && v >= (mask + 1) / 2) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic issue(input bit ld, input bit st, input int sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd);
    load_mem = ld; store_mem = st; size = sz[2:0]; sign = sg; addr = a; wdata = wd;
    #1 chk("stall_accept", stall, 1);
    @(negedge clk);
    load_mem = 0; store_mem = 0; addr = $urandom; wdata = $urandom;
    #1;
  endtask

  task automatic run_op(input bit ld, input bit st, input int sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int gd, input int rdly);
    int fc;
    int lo;
    fc = m_fault(ld, st, sz, a);
    lo = int'(a % 4);
    issue(ld, st, sz, sg, a, wd);
    if (fc >= 0) begin
      chk("fault_pulse", fault, 1);
      chk("fault_cause", fault_cause, fc);
      chk("fault_no_req", mem_req, 0);
      chk("fault_stall", stall, 0);
      return;
    end
    chk("req", mem_req, 1);
    chk("mem_addr", mem_addr, a & ~32'h3);
    chk("mem_we", mem_we, st);
    chk("mem_wstrb", mem_wstrb, m_strb(sz, lo));
    chk("mem_wdata", mem_wdata, 32'(wd << (8 * lo)));
    repeat (gd) begin
      @(negedge clk); #1;
      chk("req_hold", mem_req, 1);
    end
    mem_gnt = 1;
    @(negedge clk); mem_gnt = 0; #1;
    chk("req_drop", mem_req, 0);
    if (st) begin
      chk("store_done_stall", stall, 0);
      chk("store_no_lv", load_valid, 0);
      @(negedge clk); #1;
      chk("store_idle_lv", load_valid, 0);
      return;
    end
    chk("resp_stall", stall, 1);
    repeat (rdly) begin
      @(negedge clk); #1;
      chk("resp_wait_stall", stall, 1);
    end
    mem_rvalid = 1; mem_rdata = rd;
    @(negedge clk); mem_rvalid = 0; mem_rdata = $urandom; #1;
    exp_ld = m_load(sz, sg, lo, rd);
    chk("load_valid", load_valid, 1);
    chk("load_data", load_data, exp_ld);
    chk("done_stall", stall, 0);
    @(negedge clk); #1;
    chk("lv_pulse_end", load_valid, 0);
    chk("load_data_hold", load_data, exp_ld);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_load_data"}, load_data, 0);
    chk({tag, "_load_valid"}, load_valid, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_fault_cause"}, fault_cause, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    int sizes[10] = '{1, 2, 4, 1, 2, 4, 0, 3, 5, 7};
    rst = 1; load_mem = 0; store_mem = 0; size = 0; sign = 0; addr = 0; wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    rst = 0; #1;
    chk_all_zero("reset");

    // LB sign-extended from lane 3; load_valid lands 3 cycles after accept
    run_op(1, 0, 1, 1, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0);
    run_op(1, 0, 2, 0, 32'h2002, 32'h0, 32'hBEEF_1234, 0, 0);
    run_op(0, 1, 1, 0, 32'h3001, 32'h0000_00AA, 32'h0, 0, 0);
    run_op(1, 0, 4, 0, 32'h4002, 32'h0, 32'h0, 0, 0);
    run_op(1, 1, 4, 0, 32'h4000, 32'h0, 32'h0, 0, 0);
    run_op(1, 0, 3, 0, 32'h4000, 32'h0, 32'h0, 0, 0);
    // grant on the last allowed REQ cycle must still win over the watchdog
    run_op(0, 1, 4, 0, 32'h4444, 32'h1234_5678, 32'h0, 3, 0);
    run_op(1, 0, 2, 1, 32'h5002, 32'h0, 32'h8001_7FFF, 1, 3);

    // watchdog in REQ: four REQ cycles, then fault cause 2
    issue(1, 0, 4, 0, 32'h6000, 32'h0);
    chk("to_req_1", mem_req, 1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk); #1;
      chk("to_req_n", mem_req, 1);
    end
    @(negedge clk); #1;
    chk("to_req_fault", fault, 1);
    chk("to_req_cause", fault_cause, 2);
    chk("to_req_mem_req", mem_req, 0);
    chk("to_req_stall", stall, 0);
    @(negedge clk); #1;
    chk("to_req_pulse_end", fault, 0);

    // watchdog in RESP, then a late rvalid that must be ignored
    issue(1, 0, 1, 0, 32'h7001, 32'h0);
    mem_gnt = 1;
    @(negedge clk); mem_gnt = 0; #1;
    chk("to_resp_stall", stall, 1);
    repeat (3) @(negedge clk);
    #1 chk("to_resp_no_fault_yet", fault, 0);
    @(negedge clk); #1;
    chk("to_resp_fault", fault, 1);
    chk("to_resp_cause", fault_cause, 2);
    chk("to_resp_stall_low", stall, 0);
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); mem_rvalid = 0; #1;
    chk("late_rvalid_lv", load_valid, 0);
    chk("late_rvalid_data", load_data, exp_ld);

    // reset while waiting in RESP
    issue(1, 0, 2, 0, 32'h8000, 32'h0);
    mem_gnt = 1;
    @(negedge clk); mem_gnt = 0; rst = 1;
    @(negedge clk); #1;
    chk_all_zero("rst_resp");
    exp_ld = 32'h0;
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk); mem_rvalid = 0; #1;
    chk("rst_late_lv", load_valid, 0);
    chk("rst_late_data", load_data, 0);
    chk("rst_late_stall", stall, 0);

    for (int n = 0; n < 60; n++) begin
      bit ld, st;
      int op = $urandom_range(0, 9);
      ld = (op < 5) || (op == 9);
      st = (op >= 5);
      run_op(ld, st, sizes[$urandom_range(0, 9)], 1'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_data_port.md
Name: lsu_data_port

Overview:
- Responder side of the EX-stage memory control signals (store_mem, load_mem, size, sign) produced by the control unit.
- Accepts one load/store per request and checks alignment.
- Drives a word-wide data-memory bus with byte strobes, then returns the sign/zero-extended load result to the MEM stage.
- Holds the pipeline stalled until the access completes or faults.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_gnt or mem_rvalid before a fault; 0 disables the watchdog.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- load_mem  in  1  EX-stage load request
- store_mem  in  1  EX-stage store request
- size  in  3  access size in bytes; legal values 1, 2, 4
- sign  in  1  sign-extend load result (LB/LH)
- addr  in  ADDR_W  effective byte address
- wdata  in  32  store data, right-aligned
- stall  out  1  freeze upstream stages
- load_data  out  32  extended load result
- load_valid  out  1  one-cycle pulse; load_data valid
- fault  out  1  one-cycle pulse; misaligned, illegal, or timeout
- fault_cause  out  2  0 = misaligned, 1 = illegal size/both requests, 2 = timeout
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address (addr with bits [1:0] = 0)
- mem_wstrb  out  4  byte-lane enables
- mem_wdata  out  32  lane-shifted store data
- mem_gnt  in  1  bus accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE.
- Reset values: state = IDLE; all outputs 0, including stall, mem_req, load_data, fault_cause.
- IDLE, load_mem|store_mem high:
  - Capture addr, size, sign, wdata, direction.
  - stall is combinationally high in this same cycle.
  - Legality check:
    - load_mem and store_mem both high -> fault, cause 1.
    - size not in {1, 2, 4} -> fault, cause 1.
    - size 2 with addr[0] = 1 -> fault, cause 0.
    - size 4 with addr[1:0] != 0 -> fault, cause 0.
  - On any fault: pulse fault in the next cycle, go to IDLE, no bus access.
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1; mem_addr, mem_we, mem_wstrb, mem_wdata are stable and registered.
  - mem_wstrb: size 1 -> 0001 << addr[1:0]; size 2 -> 0011 << addr[1:0]; size 4 -> 1111. Loads use the same strobe.
  - mem_wdata = wdata << (8 * addr[1:0]).
  - On mem_gnt: a store goes to DONE; a load goes to RESP. mem_req drops in the cycle after gnt.
- RESP:
  - On mem_rvalid: select the byte/half at addr[1:0].
  - Extend to 32 bits: sign ? sign-extend : zero-extend. Size 4 passes the word through.
  - Register into load_data and go to DONE.
  - mem_rvalid in the same cycle as gnt is not allowed; rvalid arrives at least 1 cycle after gnt.
- DONE:
  - stall = 0.
  - load_valid = 1 for a load, 0 for a store.
  - Next state: IDLE.
  - load_data holds its value until the next completed load.
- Stall: high in the IDLE accept cycle, REQ, and RESP; low in DONE and in idle IDLE.
  - Minimum load latency is 3 cycles from accept to load_valid, with immediate gnt and rvalid 1 cycle later.
  - Minimum store latency is 2 cycles to DONE.
- Watchdog:
  - Counter clears on entry to REQ and on entry to RESP; increments each cycle in those states.
  - When the count reaches TIMEOUT_CYCLES without gnt/rvalid: pulse fault with cause 2, drop mem_req, go to IDLE.
  - A late rvalid after timeout is ignored.
- Simultaneous events: a request asserted in DONE is not accepted until the following IDLE cycle. Upstream holds it because stall was high until DONE.
- Reset mid-operation: any state returns to IDLE the next edge, mem_req drops, and no pulse is emitted.
- Inputs are sampled only in IDLE; changes while stalled are ignored.

Decomposition:
- Shared package holds:
  - state enum {IDLE, REQ, RESP, DONE};
  - size constants SZ_B = 1, SZ_H = 2, SZ_W = 4;
  - fault cause constants FC_MISALIGN, FC_ILLEGAL, FC_TIMEOUT.
- One natural sub-module, lsu_lane_align: combinational strobe generation, store shift, and load extract/extend. The FSM, watchdog, and registers stay in the top.

Test Plan:
- LB sign=1, addr 0x1003, rdata 0x80FF_0000 -> mem_addr 0x1000, wstrb 1000, load_data 0xFFFF_FF80, load_valid 3 cycles after accept (gnt immediate, rvalid +1).
- LHU sign=0, addr 0x2002, rdata 0xBEEF_1234 -> load_data 0x0000_BEEF.
- SB addr 0x3001, wdata 0x0000_00AA -> mem_we = 1, wstrb 0010, mem_wdata 0x0000_AA00, stall low 2 cycles after accept, no load_valid.
- LW addr 0x4002 -> fault pulse with cause 0, mem_req never asserted; load_mem+store_mem together -> cause 1.
- TIMEOUT_CYCLES = 4, mem_gnt held 0 -> fault cause 2 after 4 REQ cycles, mem_req drops, stall low the next cycle.
- rst asserted in RESP -> next cycle IDLE, all outputs 0, a subsequent rvalid is ignored.
